// File: rtl/fetch_queue_pkg.sv
// Shared types for the prefetching fetch front end: buffered entry layout,
// fetch FSM state encoding and the sequential PC step helper.
package fetch_queue_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef struct packed {
    u64 pc;
    u32 instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DISCARD
  } fq_state_t;

  // 64-bit sequential step; wraps modulo 2^64 by construction.
  function automatic u64 step_pc(input u64 pc, input int unsigned step);
    return pc + 64'(step);
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of fetched instructions; flush empties it in one cycle.
// Storage is not reset, only pointers and occupancy.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enq,
  input  fetch_entry_t                 enq_entry,
  input  logic                         deq,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= enq_entry;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch front end: one outstanding ibus request,
// credit-limited so the DEPTH-entry queue never overflows, with redirect flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fq_state_t        state;
  u64               fpc;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     enq_entry;
  logic             enq;
  logic             deq;
  logic             has_credit;

  // Nothing is in flight while IDLE, so credit reduces to free queue space.
  assign has_credit = (count < DEPTH_C);
  assign out_valid  = (count != '0);
  assign deq        = out_valid && out_ready && !redirect_valid;
  assign enq_entry  = '{pc: ireq_addr, instr: iresp_data};

  always_comb begin
    enq = 1'b0;
    if (!redirect_valid) begin
      case (state)
        REQ:     enq = iresp_addr_ok && iresp_data_ok;
        WAIT:    enq = iresp_data_ok;
        default: enq = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fpc        <= RESET_PC;
      ireq_valid <= 1'b0;
      ireq_addr  <= RESET_PC;
    end else begin
      if (redirect_valid) begin
        fpc <= redirect_pc;
      end else if (enq) begin
        fpc <= step_pc(fpc, PC_STEP);
      end

      case (state)
        IDLE: begin
          if (!redirect_valid && has_credit) begin
            state      <= REQ;
            ireq_valid <= 1'b1;
            ireq_addr  <= fpc;
          end
        end
        REQ: begin
          if (iresp_addr_ok) begin
            ireq_valid <= 1'b0;
            if (iresp_data_ok) begin
              state <= IDLE;
            end else begin
              state <= redirect_valid ? DISCARD : WAIT;
            end
          end else if (redirect_valid) begin
            state <= DISCARD;
          end
        end
        WAIT: begin
          // A redirect coinciding with data_ok just drops that response.
          if (iresp_data_ok) begin
            state <= IDLE;
          end else if (redirect_valid) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          // The bus forbids withdrawing valid before addr_ok, so ride it out.
          if (ireq_valid) begin
            if (iresp_addr_ok) begin
              ireq_valid <= 1'b0;
              if (iresp_data_ok) begin
                state <= IDLE;
              end
            end
          end else if (iresp_data_ok) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          ireq_valid <= 1'b0;
        end
      endcase
    end
  end

  fetch_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .enq       (enq),
    .enq_entry (enq_entry),
    .deq       (deq),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;

endmodule
